fifo_pair_reader: RTL and testbench

Read-side consumer for the butterfly datapath's nonblocking FIFO. It pops words through the FIFO's read port (`re_en` / `data_out` / `empty`) and assembles consecutive words into (a, b) operand pairs. Each pair is presented to the downstream butterfly stage on a valid/ready handshake, with a last-of-frame flag driven by a pair counter. It sits between the operand FIFO and the butterfly compute unit.

---
 rtl/butterfly_pkg.sv | 18 +
 rtl/fifo_pair_reader.sv | 106 ++++++++++
 tb/tb_fifo_pair_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_pkg.sv
// Shared types for the butterfly datapath: operand width default,
// read-side FSM state encoding and the (a, b) operand pair.
package butterfly_pkg;

  localparam int BF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FETCH_A = 2'd0,
    FETCH_B = 2'd1,
    HOLD    = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [BF_DATA_WIDTH-1:0] a;
    logic [BF_DATA_WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/fifo_pair_reader.sv
// Pops words from a first-word-fall-through FIFO and presents consecutive
// words as (a, b) operand pairs on a valid/ready handshake. A pair counter
// tags the last pair of each butterfly frame.
module fifo_pair_reader
  import butterfly_pkg::*;
#(
  parameter int DATA_WIDTH      = BF_DATA_WIDTH,
  parameter int PAIRS_PER_FRAME = 16,
  parameter int CNT_W           = (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_W-1:0]      pair_cnt
);

  rd_state_t state_reg;
  logic      pop;
  logic      handshake;
  logic      last_pair;

  // A pair is only ever presented while in HOLD, so the handshake is
  // qualified by state rather than by out_valid.
  assign handshake = (state_reg == HOLD) && out_ready;
  assign last_pair = (pair_cnt == CNT_W'(PAIRS_PER_FRAME - 1));
  assign fifo_re   = pop;

  // Pop strobe: fetch states pop freely; HOLD pops only when the held pair
  // leaves in the same cycle (back-to-back path). Gated by rst so the FIFO
  // never sees a read while both sides are being cleared.
  always_comb begin
    pop = 1'b0;
    if (!rst && enable && !fifo_empty) begin
      case (state_reg)
        FETCH_A: pop = 1'b1;
        FETCH_B: pop = 1'b1;
        HOLD:    pop = out_ready;
        default: pop = 1'b0;
      endcase
    end
  end

  // FSM plus operand registers; a captured a-word is kept across stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH_A;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        FETCH_A: begin
          if (pop) begin
            out_a     <= fifo_data;
            state_reg <= FETCH_B;
          end
        end
        FETCH_B: begin
          if (pop) begin
            out_b     <= fifo_data;
            out_valid <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              out_a     <= fifo_data;
              state_reg <= FETCH_B;
            end else begin
              state_reg <= FETCH_A;
            end
          end
        end
        default: begin
          state_reg <= FETCH_A;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Frame pair counter and last flag: the flag is latched with the b-word,
  // the counter advances (and wraps) on each accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt <= '0;
      out_last <= 1'b0;
    end else if ((state_reg == FETCH_B) && pop) begin
      out_last <= last_pair;
    end else if (handshake) begin
      out_last <= 1'b0;
      pair_cnt <= last_pair ? '0 : pair_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_pair_reader.sv
// Randomized scoreboard bench for fifo_pair_reader. The FIFO is modelled as a
// queue; every second word written completes an expected pair whose frame
// index and last flag follow from the pair's ordinal. A monitor on the
// falling edge checks accepted pairs, the pop rule and hold stability.
module tb_fifo_pair_reader;
  import butterfly_pkg::*;

  localparam int DW  = 8;
  localparam int PPF = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_re;
  logic [DW-1:0] out_a, out_b;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [CW-1:0] pair_cnt;

  typedef struct {
    operand_pair_t p;
    bit            last;
    int            idx;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fq[$];
  int            errors = 0;
  int            checks = 0;
  int            words_pushed = 0;
  int            pairs_expected = 0;
  int            pairs_seen = 0;
  logic [DW-1:0] pending_a = '0;
  bit            re_sampled;

  fifo_pair_reader #(
    .DATA_WIDTH(DW),
    .PAIRS_PER_FRAME(PPF),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_re(fifo_re),
    .out_a(out_a),
    .out_b(out_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? DW'($urandom) : fq[0];
  endtask

  // Writing a word into the FIFO model; every odd word closes a pair.
  task automatic push_word(input logic [DW-1:0] w);
    exp_t e;
    fq.push_back(w);
    if (words_pushed % 2 == 0) begin
      pending_a = w;
    end else begin
      e.p.a = pending_a;
      e.p.b = w;
      e.idx = pairs_expected % PPF;
      e.last = (e.idx == PPF - 1);
      sb.push_back(e);
      pairs_expected++;
    end
    words_pushed++;
    drive_fifo();
  endtask

  // One clock: sample the pop strobe mid-cycle, then retire the popped word
  // just after the edge so inputs change away from the active edge.
  task automatic tick();
    @(negedge clk);
    re_sampled = fifo_re;
    @(posedge clk);
    #1;
    if (re_sampled && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = out_valid;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    if (words_pushed % 2 == 1) push_word(DW'($urandom));
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = (sb.size() == 0) && (fq.size() == 0) && !out_valid;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic random_phase(input int cycles, input int push_pct, input int en_off_pct);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 99) < push_pct) push_word(DW'($urandom));
      enable = ($urandom_range(0, 99) >= en_off_pct);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_fifo();
      tick();
    end
  endtask

  // Monitor: decoupled from stimulus; everything sampled mid-cycle.
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_a, prev_b;
  logic          prev_last, prev_valid;
  logic [CW-1:0] prev_cnt;

  always @(negedge clk) begin
    exp_t e;
    bit   exp_re;
    if (rst) begin
      hold_prev = 1'b0;
      chk("re_in_reset", {31'd0, fifo_re}, 32'd0);
    end else begin
      exp_re = enable && !fifo_empty && (!out_valid || out_ready);
      chk("pop_rule", {31'd0, fifo_re}, {31'd0, exp_re});
      if (hold_prev) begin
        chk("hold_stable", {out_a, out_b, 5'd0, prev_valid ? out_valid : 1'b1, out_last, pair_cnt},
            {prev_a, prev_b, 5'd0, 1'b1, prev_last, prev_cnt});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair: got a=%02h b=%02h expected none", out_a, out_b);
        end else begin
          e = sb.pop_front();
          $display("pair %0d: a=%02h b=%02h last=%0b cnt=%0d", pairs_seen, out_a, out_b, out_last, pair_cnt);
          chk("pair_a", {24'd0, out_a}, {24'd0, e.p.a});
          chk("pair_b", {24'd0, out_b}, {24'd0, e.p.b});
          chk("pair_last", {31'd0, out_last}, {31'd0, e.last});
          chk("pair_cnt", {30'd0, pair_cnt}, e.idx);
        end
        pairs_seen++;
      end
      hold_prev  = out_valid && !out_ready;
      prev_a     = out_a;
      prev_b     = out_b;
      prev_last  = out_last;
      prev_valid = out_valid;
      prev_cnt   = pair_cnt;
    end
  end

  initial begin
    rst = 1'b1;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a", {24'd0, out_a}, 32'd0);
    chk("rst_b", {24'd0, out_b}, 32'd0);
    chk("rst_cnt", {30'd0, pair_cnt}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_re", {31'd0, fifo_re}, 32'd0);
    rst = 1'b0;

    // Streaming from a preloaded FIFO.
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    enable = 1'b1;
    out_ready = 1'b1;
    drive_fifo();
    repeat (12) tick();
    drain("drain_stream");

    random_phase(1500, 45, 10);
    drain("drain_rand1");

    // Reset while a pair is held and a pop would otherwise be allowed.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    wait_valid("reset_hold_reached");
    push_word(8'h12);
    push_word(8'h34);
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_a", {24'd0, out_a}, 32'd0);
    chk("midrst_b", {24'd0, out_b}, 32'd0);
    chk("midrst_cnt", {30'd0, pair_cnt}, 32'd0);
    chk("midrst_re", {31'd0, fifo_re}, 32'd0);
    fq.delete();
    sb.delete();
    words_pushed = 0;
    pairs_expected = 0;
    drive_fifo();
    repeat (2) tick();
    rst = 1'b0;

    // Backpressure: pair (AA, BB) held for 5 cycles, next word waits.
    out_ready = 1'b0;
    push_word(8'hAA);
    push_word(8'hBB);
    wait_valid("bp_valid");
    push_word(8'hCC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_a", {24'd0, out_a}, 32'hAA);
      chk("bp_b", {24'd0, out_b}, 32'hBB);
      chk("bp_re", {31'd0, fifo_re}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_pop_on_ready", {31'd0, fifo_re}, 32'd1);
    tick();
    chk("bp_next_a", {24'd0, out_a}, 32'hCC);
    chk("bp_valid_low", {31'd0, out_valid}, 32'd0);
    push_word(8'hDD);
    drain("drain_bp");

    // Empty stall with a partial pair.
    push_word(8'h5C);
    repeat (5) tick();
    chk("stall_a", {24'd0, out_a}, 32'h5C);
    chk("stall_valid", {31'd0, out_valid}, 32'd0);
    push_word(8'h6D);
    tick();
    chk("stall_pair_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_pair_a", {24'd0, out_a}, 32'h5C);
    chk("stall_pair_b", {24'd0, out_b}, 32'h6D);
    drain("drain_stall");

    // Enable dropped after the a-word pops.
    push_word(8'hEE);
    tick();
    enable = 1'b0;
    push_word(8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_hold_a", {24'd0, out_a}, 32'hEE);
      chk("en_no_re", {31'd0, fifo_re}, 32'd0);
    end
    enable = 1'b1;
    #1;
    chk("en_re_back", {31'd0, fifo_re}, 32'd1);
    tick();
    chk("en_pair_valid", {31'd0, out_valid}, 32'd1);
    chk("en_pair_b", {24'd0, out_b}, 32'hFF);
    drain("drain_en");

    random_phase(1500, 55, 30);
    drain("drain_rand2");
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
